trigger_capture: RTL and testbench

TRIGGER_CAPTURE -- requirements
Module: trigger_capture

---
 rtl/trigger_capture.sv | 112 +++++++++++
 tb/tb_trigger_capture.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/trigger_capture.sv
// trigger_capture: edge/auto-triggered frame capture into a sample buffer; TRIGGER_HYSTERESIS_EN enables trigger arming hysteresis
module trigger_capture #(
  parameter int DATA_W       = 12,
  parameter int ADDR_W       = 11,
  parameter int DEPTH        = 640,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int HYST         = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] threshold,
  input  logic              edge_sel,
  input  logic              auto_mode,
  input  logic              hold,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              triggered,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  localparam int CW = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(AUTO_TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  state_t st;
  logic [DATA_W-1:0] prev;
  logic prev_valid;
  logic [CW-1:0] cnt;
  logic rise_ok, fall_ok, rise, fall, hit, timeout;
`ifdef TRIGGER_HYSTERESIS_EN
  logic arm_r, arm_f;
  logic [DATA_W:0] lo_diff, hi_sum;
  logic [DATA_W-1:0] lo, hi;
  assign lo_diff = {1'b0, threshold} - (DATA_W+1)'(HYST);
  assign hi_sum  = {1'b0, threshold} + (DATA_W+1)'(HYST);
  assign lo = lo_diff[DATA_W] ? '0 : lo_diff[DATA_W-1:0];
  assign hi = hi_sum[DATA_W] ? '1 : hi_sum[DATA_W-1:0];
  assign rise_ok = arm_r;
  assign fall_ok = arm_f;
  // Arming flags only accumulate while ARMED, so every arming restarts them
  always_ff @(posedge clock) begin
    if (reset || st != ARMED) begin
      arm_r <= 1'b0;
      arm_f <= 1'b0;
    end else if (sample_en) begin
      arm_r <= arm_r | (data < lo);
      arm_f <= arm_f | (data > hi);
    end
  end
`else
  assign rise_ok = 1'b1;
  assign fall_ok = 1'b1;
`endif
  assign rise    = prev_valid && rise_ok && prev < threshold && data >= threshold;
  assign fall    = prev_valid && fall_ok && prev > threshold && data <= threshold;
  assign hit     = edge_sel ? fall : rise;
  assign timeout = auto_mode && cnt == TO_LAST;
  assign state   = st;
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      triggered  <= 1'b0;
      prev       <= '0;
      prev_valid <= 1'b0;
      cnt        <= '0;
    end else begin
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      case (st)
        IDLE: if (!hold) begin
          st         <= ARMED;
          prev_valid <= 1'b0;
          cnt        <= '0;
        end
        ARMED: begin
          cnt <= !auto_mode ? '0 : sample_en ? cnt + 1'b1 : cnt;
          if (hold) st <= IDLE;
          else if (sample_en) begin
            prev       <= data;
            prev_valid <= 1'b1;
            if (hit || timeout) begin
              st        <= (DEPTH == 1) ? DONE : CAPTURE;
              triggered <= hit;
              wr_en     <= 1'b1;
              wr_addr   <= '0;
              wr_data   <= data;
            end
          end
        end
        CAPTURE: if (sample_en) begin
          wr_en   <= 1'b1;
          wr_addr <= wr_addr + 1'b1;
          wr_data <= data;
          if (wr_addr + 1'b1 == LAST) st <= DONE;
        end
        DONE: begin
          frame_done <= 1'b1;
          st         <= hold ? IDLE : ARMED;
          prev_valid <= 1'b0;
          cnt        <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_trigger_capture.sv
// tb_trigger_capture: directed scoreboard bench for trigger_capture
module tb_trigger_capture;
  logic clock = 1'b0;
  logic reset, sample_en, edge_sel, auto_mode, hold;
  logic [11:0] data, threshold;
  logic wr_en, frame_done, triggered;
  logic [10:0] wr_addr;
  logic [11:0] wr_data;
  logic [1:0] state;
  typedef struct {int addr; int data;} wr_t;
  wr_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int fd_cnt = 0;
  int fd_before;
  trigger_capture dut (
    .clock(clock), .reset(reset), .sample_en(sample_en), .data(data),
    .threshold(threshold), .edge_sel(edge_sel), .auto_mode(auto_mode), .hold(hold),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .frame_done(frame_done),
    .triggered(triggered), .state(state)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic tick();
    wr_t e;
    @(posedge clock);
    #1;
    if (frame_done) fd_cnt++;
    if (wr_en) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL wr_unexpected: observed write addr %0d data %0d expected no write", wr_addr, wr_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(wr_addr), 32'(e.addr));
        chk("wr_data", 32'(wr_data), 32'(e.data));
      end
    end
  endtask
  task automatic smp(input logic [11:0] d, input bit w, input int a);
    data = d;
    sample_en = 1'b1;
    if (w) exp_q.push_back('{a, int'(d)});
    tick();
    sample_en = 1'b0;
  endtask
  initial begin
    reset = 1'b1; sample_en = 1'b0; data = '0; threshold = 12'd2048;
    edge_sel = 1'b0; auto_mode = 1'b0; hold = 1'b1;
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("rst_wr_data", 32'(wr_data), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_triggered", 32'(triggered), 32'd0);
    reset = 1'b0;
    tick();
    chk("idle_hold", 32'(state), 32'd0);
    hold = 1'b0;
    tick();
    chk("armed", 32'(state), 32'd1);
    // rising ramp through the threshold
    for (int d = 2040; d < 2048; d++) smp(12'(d), 1'b0, 0);
    chk("ramp_no_trig", 32'(state), 32'd1);
    smp(12'd2048, 1'b1, 0);
    chk("ramp_trig_state", 32'(state), 32'd2);
    chk("ramp_triggered", 32'(triggered), 32'd1);
    for (int a = 1; a < 640; a++) smp(12'(2048 + a), 1'b1, a);
    chk("ramp_done_state", 32'(state), 32'd3);
    chk("ramp_fd_early", 32'(fd_cnt), 32'd0);
    tick();
    chk("ramp_fd_pulse", 32'(frame_done), 32'd1);
    chk("ramp_rearm", 32'(state), 32'd1);
    tick();
    chk("ramp_fd_single", 32'(frame_done), 32'd0);
    chk("ramp_sb_empty", 32'(exp_q.size()), 32'd0);
    // falling slope: hold beats edge, prev_valid cleared on re-arm, hold ignored mid-capture
    edge_sel = 1'b1;
    smp(12'd2060, 1'b0, 0);
    hold = 1'b1;
    smp(12'd2040, 1'b0, 0);
    chk("hold_beats_edge", 32'(state), 32'd0);
    hold = 1'b0;
    tick();
    chk("rearm_after_hold", 32'(state), 32'd1);
    smp(12'd2040, 1'b0, 0);
    chk("prev_valid_cleared", 32'(state), 32'd1);
    smp(12'd2060, 1'b0, 0);
    smp(12'd2040, 1'b1, 0);
    chk("fall_trig_state", 32'(state), 32'd2);
    chk("fall_triggered", 32'(triggered), 32'd1);
    for (int a = 1; a < 640; a++) begin
      if (a == 300) hold = 1'b1;
      smp(12'(a * 3), 1'b1, a);
      if (a == 300) chk("hold_ignored_capture", 32'(state), 32'd2);
    end
    chk("hold_done_state", 32'(state), 32'd3);
    tick();
    chk("hold_to_idle", 32'(state), 32'd0);
    chk("hold_fd_pulse", 32'(frame_done), 32'd1);
    chk("hold_sb_empty", 32'(exp_q.size()), 32'd0);
    // reset mid-capture abandons the frame
    hold = 1'b0;
    edge_sel = 1'b0;
    tick();
    chk("rst_test_armed", 32'(state), 32'd1);
    smp(12'd2000, 1'b0, 0);
    smp(12'd2100, 1'b1, 0);
    for (int a = 1; a < 200; a++) smp(12'(a + 500), 1'b1, a);
    reset = 1'b1; sample_en = 1'b1; data = 12'd7;
    tick();
    reset = 1'b0; sample_en = 1'b0; hold = 1'b1;
    chk("midrst_state", 32'(state), 32'd0);
    chk("midrst_wr_en", 32'(wr_en), 32'd0);
    chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
    chk("midrst_triggered", 32'(triggered), 32'd0);
    fd_before = fd_cnt;
    repeat (5) tick();
    chk("midrst_no_fd", 32'(fd_cnt), 32'(fd_before));
    chk("midrst_sb_empty", 32'(exp_q.size()), 32'd0);
    // auto-mode forced trigger on constant data
    hold = 1'b0;
    auto_mode = 1'b1;
    tick();
    chk("auto_armed", 32'(state), 32'd1);
    for (int n = 1; n < 4096; n++) smp(12'd100, 1'b0, 0);
    chk("auto_before_timeout", 32'(state), 32'd1);
    smp(12'd100, 1'b1, 0);
    chk("auto_trig_state", 32'(state), 32'd2);
    chk("auto_triggered", 32'(triggered), 32'd0);
    for (int a = 1; a < 640; a++) smp(12'd100, 1'b1, a);
    chk("auto_done_state", 32'(state), 32'd3);
    tick();
    chk("auto_fd_pulse", 32'(frame_done), 32'd1);
    chk("auto_rearm", 32'(state), 32'd1);
    auto_mode = 1'b0;
    // noise around the threshold
`ifdef TRIGGER_HYSTERESIS_EN
    for (int i = 0; i < 5; i++) begin
      smp(12'd2045, 1'b0, 0);
      smp(12'd2050, 1'b0, 0);
    end
    chk("hyst_noise_no_trig", 32'(state), 32'd1);
    smp(12'd2030, 1'b0, 0);
    chk("hyst_dip_no_trig", 32'(state), 32'd1);
    smp(12'd2050, 1'b1, 0);
`else
    smp(12'd2045, 1'b0, 0);
    smp(12'd2050, 1'b1, 0);
`endif
    chk("noise_trig_state", 32'(state), 32'd2);
    chk("noise_triggered", 32'(triggered), 32'd1);
    for (int a = 1; a < 640; a++) smp(12'(a), 1'b1, a);
    tick(); tick();
    chk("total_frames", 32'(fd_cnt), 32'd4);
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
